maze_room_engine: RTL

Parametrised room/map engine for the meikyuu maze game, placed between the VGA timing counters, the player module and the colour mux. It holds a loadable MAP_W×MAP_H tile map in which each tile is a 4-bit open-side mask, so any of the 16 corridor, L, T, cross and dead-end shapes can be expressed. It produces a pipelined per-pixel wall flag for rendering. It also arbitrates player move requests: collision check, room transition at screen edges, and optional toroidal wrap.

---
 rtl/maze_pkg.sv | 33 +++
 rtl/maze_wall_test.sv | 39 +++
 rtl/maze_room_engine.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze room engine: side bit indices, named tile masks and FSM states.
package maze_pkg;

    // Open-side mask bit positions, mask = {up, right, down, left}
    localparam int unsigned UP    = 3;
    localparam int unsigned RIGHT = 2;
    localparam int unsigned DOWN  = 1;
    localparam int unsigned LEFT  = 0;

    localparam logic [3:0] CLOSED       = 4'b0000;
    localparam logic [3:0] VERT         = 4'b1010;
    localparam logic [3:0] HORIZ        = 4'b0101;
    localparam logic [3:0] CROSS        = 4'b1111;
    localparam logic [3:0] L_UP_RIGHT   = 4'b1100;
    localparam logic [3:0] L_RIGHT_DOWN = 4'b0110;
    localparam logic [3:0] L_DOWN_LEFT  = 4'b0011;
    localparam logic [3:0] L_LEFT_UP    = 4'b1001;
    localparam logic [3:0] T_NO_UP      = 4'b0111;
    localparam logic [3:0] T_NO_RIGHT   = 4'b1011;
    localparam logic [3:0] T_NO_DOWN    = 4'b1101;
    localparam logic [3:0] T_NO_LEFT    = 4'b1110;
    localparam logic [3:0] DEAD_UP      = 4'b1000;
    localparam logic [3:0] DEAD_RIGHT   = 4'b0100;
    localparam logic [3:0] DEAD_DOWN    = 4'b0010;
    localparam logic [3:0] DEAD_LEFT    = 4'b0001;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StResp
    } state_e;

endpackage

// File: rtl/maze_wall_test.sv
// Combinational box-versus-tile test: does the box [x, x+size) x [y, y+size) touch any wall region.
module maze_wall_test
    import maze_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int WALL  = 100
) (
    input  logic signed [12:0] x,
    input  logic signed [12:0] y,
    input  logic        [10:0] size,
    input  logic        [3:0]  mask,
    output logic               wall
);

    localparam logic signed [12:0] WallLim  = 13'(WALL);
    localparam logic signed [12:0] RightLim = 13'(H_ACT - WALL);
    localparam logic signed [12:0] BotLim   = 13'(V_ACT - WALL);

    logic signed [12:0] x_end;
    logic signed [12:0] y_end;
    logic               in_l, in_r, in_u, in_d;

    // Bands are half-planes, so a box partly off-screen still meets the band it straddles
    always_comb begin
        x_end = x + $signed({2'b00, size});
        y_end = y + $signed({2'b00, size});
        in_l  = x < WallLim;
        in_r  = x_end > RightLim;
        in_u  = y < WallLim;
        in_d  = y_end > BotLim;
        wall  = ((in_l | in_r) & (in_u | in_d))
              | (in_l & ~mask[LEFT])
              | (in_r & ~mask[RIGHT])
              | (in_u & ~mask[UP])
              | (in_d & ~mask[DOWN]);
    end

endmodule

// File: rtl/maze_room_engine.sv
// Room/map engine: loadable tile map, 2-stage per-pixel wall flag and player move arbitration.
module maze_room_engine
    import maze_pkg::*;
#(
    parameter int MAP_W  = 3,
    parameter int MAP_H  = 3,
    parameter int WALL   = 100,
    parameter int PLAYER = 16,
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int WRAP   = 0
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic        [9:0]  pix_x,
    input  logic        [9:0]  pix_y,
    input  logic               pix_valid,
    output logic               wall_pix,
    output logic               wall_valid,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [10:0] req_x,
    input  logic signed [10:0] req_y,
    output logic               resp_valid,
    output logic               resp_accept,
    output logic        [9:0]  pos_x,
    output logic        [9:0]  pos_y,
    output logic        [3:0]  room_x,
    output logic        [3:0]  room_y,
    output logic               room_changed,
    input  logic               map_we,
    input  logic        [7:0]  map_addr,
    input  logic        [3:0]  map_data
);

    localparam logic [9:0]         PosXRst  = 10'(H_ACT / 2 - PLAYER / 2);
    localparam logic [9:0]         PosYRst  = 10'(V_ACT / 2 - PLAYER / 2);
    localparam logic [9:0]         PosXMax  = 10'(H_ACT - PLAYER);
    localparam logic [9:0]         PosYMax  = 10'(V_ACT - PLAYER);
    localparam logic signed [12:0] XLimit   = 13'(H_ACT - PLAYER);
    localparam logic signed [12:0] YLimit   = 13'(V_ACT - PLAYER);
    localparam logic [3:0]         LastCol  = 4'(MAP_W - 1);
    localparam logic [3:0]         LastRow  = 4'(MAP_H - 1);

    state_e state_q, state_d;

    logic [3:0] map_q [MAP_H][MAP_W];
    logic [3:0] cur_tile;

    logic [9:0] s1_x_q, s1_y_q;
    logic       s1_valid_q;
    logic [3:0] s1_tile_q;
    logic       pix_wall;
    logic       wall_pix_q, wall_valid_q;

    logic signed [10:0] req_x_q, req_x_d, req_y_q, req_y_d;
    logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [3:0]         room_x_q, room_x_d, room_y_q, room_y_d;
    logic               resp_accept_q, resp_accept_d;
    logic               room_changed_q, room_changed_d;

    logic signed [12:0] box_x, box_y;
    logic               box_wall;
    logic               cross_l, cross_r, cross_u, cross_d;
    logic               dec_accept, dec_changed;
    logic [9:0]         dec_pos_x, dec_pos_y;
    logic [3:0]         dec_room_x, dec_room_y;

    // Tile map
    always_comb begin
        cur_tile = CLOSED;
        for (int r = 0; r < MAP_H; r++) begin
            for (int c = 0; c < MAP_W; c++) begin
                if (room_y_q == r[3:0] && room_x_q == c[3:0]) begin
                    cur_tile = map_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < MAP_H; r++) begin
                for (int c = 0; c < MAP_W; c++) begin
                    map_q[r][c] <= CLOSED;
                end
            end
        end else if (map_we) begin
            for (int r = 0; r < MAP_H; r++) begin
                for (int c = 0; c < MAP_W; c++) begin
                    if (map_addr == {r[3:0], c[3:0]}) begin
                        map_q[r][c] <= map_data;
                    end
                end
            end
        end
    end

    // Pixel path
    maze_wall_test #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .WALL  (WALL)
    ) u_pix_test (
        .x    ({3'b000, s1_x_q}),
        .y    ({3'b000, s1_y_q}),
        .size (11'd1),
        .mask (s1_tile_q),
        .wall (pix_wall)
    );

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_tile_q    <= CLOSED;
            wall_pix_q   <= 1'b0;
            wall_valid_q <= 1'b0;
        end else begin
            s1_x_q       <= pix_x;
            s1_y_q       <= pix_y;
            s1_valid_q   <= pix_valid;
            s1_tile_q    <= cur_tile;
            wall_pix_q   <= s1_valid_q & pix_wall;
            wall_valid_q <= s1_valid_q;
        end
    end

    assign wall_pix   = wall_pix_q;
    assign wall_valid = wall_valid_q;

    // Move decision, evaluated on the captured request while in StCheck
    assign box_x = {{2{req_x_q[10]}}, req_x_q};
    assign box_y = {{2{req_y_q[10]}}, req_y_q};

    maze_wall_test #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .WALL  (WALL)
    ) u_box_test (
        .x    (box_x),
        .y    (box_y),
        .size (11'(PLAYER)),
        .mask (cur_tile),
        .wall (box_wall)
    );

    always_comb begin
        cross_l     = req_x_q[10];
        cross_r     = box_x > XLimit;
        cross_u     = req_y_q[10];
        cross_d     = box_y > YLimit;
        dec_accept  = 1'b0;
        dec_changed = 1'b0;
        dec_pos_x   = req_x_q[9:0];
        dec_pos_y   = req_y_q[9:0];
        dec_room_x  = room_x_q;
        dec_room_y  = room_y_q;
        if (box_wall) begin
            dec_accept = 1'b0;
        end else if (!(cross_l | cross_r | cross_u | cross_d)) begin
            dec_accept = 1'b1;
        end else if ((cross_l | cross_r) && (cross_u | cross_d)) begin
            dec_accept = 1'b0;
        end else begin
            dec_changed = 1'b1;
            if (cross_l) begin
                dec_pos_x = PosXMax;
                if (room_x_q != 4'd0) begin
                    dec_room_x = room_x_q - 4'd1;
                    dec_accept = 1'b1;
                end else if (WRAP != 0) begin
                    dec_room_x = LastCol;
                    dec_accept = 1'b1;
                end
            end else if (cross_r) begin
                dec_pos_x = '0;
                if (room_x_q != LastCol) begin
                    dec_room_x = room_x_q + 4'd1;
                    dec_accept = 1'b1;
                end else if (WRAP != 0) begin
                    dec_room_x = 4'd0;
                    dec_accept = 1'b1;
                end
            end else if (cross_u) begin
                dec_pos_y = PosYMax;
                if (room_y_q != 4'd0) begin
                    dec_room_y = room_y_q - 4'd1;
                    dec_accept = 1'b1;
                end else if (WRAP != 0) begin
                    dec_room_y = LastRow;
                    dec_accept = 1'b1;
                end
            end else begin
                dec_pos_y = '0;
                if (room_y_q != LastRow) begin
                    dec_room_y = room_y_q + 4'd1;
                    dec_accept = 1'b1;
                end else if (WRAP != 0) begin
                    dec_room_y = 4'd0;
                    dec_accept = 1'b1;
                end
            end
        end
    end

    // Request FSM
    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        req_x_d        = req_x_q;
        req_y_d        = req_y_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        room_x_d       = room_x_q;
        room_y_d       = room_y_q;
        resp_accept_d  = 1'b0;
        room_changed_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_x_d = req_x;
                    req_y_d = req_y;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                resp_accept_d  = dec_accept;
                room_changed_d = dec_accept & dec_changed;
                if (dec_accept) begin
                    pos_x_d  = dec_pos_x;
                    pos_y_d  = dec_pos_y;
                    room_x_d = dec_room_x;
                    room_y_d = dec_room_y;
                end
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            req_x_q        <= '0;
            req_y_q        <= '0;
            pos_x_q        <= PosXRst;
            pos_y_q        <= PosYRst;
            room_x_q       <= '0;
            room_y_q       <= '0;
            resp_accept_q  <= 1'b0;
            room_changed_q <= 1'b0;
        end else begin
            req_x_q        <= req_x_d;
            req_y_q        <= req_y_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            room_x_q       <= room_x_d;
            room_y_q       <= room_y_d;
            resp_accept_q  <= resp_accept_d;
            room_changed_q <= room_changed_d;
        end
    end

    assign resp_accept  = resp_accept_q;
    assign room_changed = room_changed_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign room_x       = room_x_q;
    assign room_y       = room_y_q;

endmodule
